// File: rtl/fft_out_reorder.sv
// fft_out_reorder: takes a 512-point FFT frame in bit-reversed order, 16 lanes per beat,
// and replays it in natural bin order from a two-bank ping-pong store.
//
// Handshake: valid_in is a pure qualifier. There is no ready, so every cycle with
// valid_in=1 (outside reset) is one accepted beat. valid_out is likewise a pure
// qualifier. The consumer must take every output beat, and dout_* are 0 whenever
// valid_out is 0.
module fft_out_reorder #(
    parameter int DATA_W = 13,
    parameter int LANES  = 16,
    parameter int N      = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] din_re  [0:LANES-1],
    input  logic signed [DATA_W-1:0] din_im  [0:LANES-1],
    output logic signed [DATA_W-1:0] dout_re [0:LANES-1],
    output logic signed [DATA_W-1:0] dout_im [0:LANES-1],
    output logic                     valid_out,
    output logic [4:0]               out_idx,
    output logic                     frame_done
);
    localparam int BEATS = N / LANES;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t     state, state_nx;
    logic [4:0] wr_cnt;
    logic       wr_bank;
    logic       wr_done;
    logic [4:0] rd_cnt, rd_cnt_nx;
    logic       rd_bank, rd_bank_nx;
    logic       other_bank;
    logic [1:0] full, full_nx;
    logic [4:0] src_rev;
    logic [3:0] src_lane;
    logic [4:0] src_beat [0:LANES-1];

    // Storage is indexed [bank][input beat][input lane], so it is exactly the arrival layout.
    logic signed [DATA_W-1:0] mem_re [0:1][0:BEATS-1][0:LANES-1];
    logic signed [DATA_W-1:0] mem_im [0:1][0:BEATS-1][0:LANES-1];

    function automatic logic [4:0] rev5(input logic [4:0] x);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = x[4-i];
        return r;
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = x[3-i];
        return r;
    endfunction

    assign wr_done    = valid_in && (wr_cnt == 5'(BEATS - 1));
    assign other_bank = ~rd_bank;

    // Write pointer: advances per accepted beat, flips bank at the end of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (valid_in) begin
            wr_cnt <= wr_cnt + 5'd1;
            if (wr_cnt == 5'(BEATS - 1)) wr_bank <= ~wr_bank;
        end
    end

    // Sample store. It is not reset because its contents are only visible through gated reads.
    always_ff @(posedge clk) begin
        if (!rst && valid_in) begin
            for (int l = 0; l < LANES; l++) begin
                mem_re[wr_bank][wr_cnt][l] <= din_re[l];
                mem_im[wr_bank][wr_cnt][l] <= din_im[l];
            end
        end
    end

    // Read FSM state, read pointer and bank-full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            full    <= '0;
        end else begin
            state   <= state_nx;
            rd_cnt  <= rd_cnt_nx;
            rd_bank <= rd_bank_nx;
            full    <= full_nx;
        end
    end

    // Next-state logic. A bank is marked full when its frame completes and cleared when its read starts.
    always_comb begin
        state_nx   = state;
        rd_cnt_nx  = rd_cnt;
        rd_bank_nx = rd_bank;
        full_nx    = full;
        if (wr_done) full_nx[wr_bank] = 1'b1;
        case (state)
            IDLE: begin
                if (wr_done) begin
                    state_nx         = READ;
                    rd_bank_nx       = wr_bank;
                    rd_cnt_nx        = '0;
                    full_nx[wr_bank] = 1'b0;
                end
            end
            READ: begin
                rd_cnt_nx = rd_cnt + 5'd1;
                if (rd_cnt == 5'(BEATS - 1)) begin
                    // Includes a frame finishing on this very edge, so there is no bubble.
                    if (full_nx[other_bank]) begin
                        rd_bank_nx          = other_bank;
                        full_nx[other_bank] = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output bin k = 16m + l lives at position bitrev9(k) = {rev4(l), rev5(m)}:
    // beat {rev4(l), rev5(m)[4]}, lane rev5(m)[3:0].
    always_comb begin
        src_rev  = rev5(rd_cnt_nx);
        src_lane = src_rev[3:0];
        for (int l = 0; l < LANES; l++) src_beat[l] = {rev4(4'(l)), src_rev[4]};
    end

    // Registered outputs, loaded from the next read position.
    // Beat m=0 reads only even input beats, so beat 31 landing on the same edge is never needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            out_idx    <= '0;
            for (int l = 0; l < LANES; l++) begin
                dout_re[l] <= '0;
                dout_im[l] <= '0;
            end
        end else begin
            valid_out  <= (state_nx == READ);
            frame_done <= (state_nx == READ) && (rd_cnt_nx == 5'(BEATS - 1));
            out_idx    <= (state_nx == READ) ? rd_cnt_nx : 5'd0;
            for (int l = 0; l < LANES; l++) begin
                dout_re[l] <= (state_nx == READ) ? mem_re[rd_bank_nx][src_beat[l]][src_lane] : '0;
                dout_im[l] <= (state_nx == READ) ? mem_im[rd_bank_nx][src_beat[l]][src_lane] : '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: randomized frames checked against a bin-order model of the reorder.
module tb_fft_out_reorder;
    localparam int DATA_W = 13;
    localparam int LANES  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic signed [DATA_W-1:0] din_re  [0:LANES-1];
    logic signed [DATA_W-1:0] din_im  [0:LANES-1];
    logic signed [DATA_W-1:0] dout_re [0:LANES-1];
    logic signed [DATA_W-1:0] dout_im [0:LANES-1];
    logic       valid_out;
    logic [4:0] out_idx;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Stimulus frames indexed by frame position n = 16c + l.
    logic signed [DATA_W-1:0] stim_re [0:2][0:511];
    logic signed [DATA_W-1:0] stim_im [0:2][0:511];

    // Captured output beats.
    logic                     cap_valid [0:95];
    logic [4:0]               cap_idx   [0:95];
    logic                     cap_done  [0:95];
    logic signed [DATA_W-1:0] cap_re    [0:95][0:15];
    logic signed [DATA_W-1:0] cap_im    [0:95][0:15];
    logic cap_after;
    int   first_cyc;
    int   t31;
    bit   timeout;

    fft_out_reorder #(.DATA_W(DATA_W), .LANES(LANES), .N(512)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .din_re(din_re), .din_im(din_im),
        .dout_re(dout_re), .dout_im(dout_im),
        .valid_out(valid_out), .out_idx(out_idx), .frame_done(frame_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int bitrev9(input int k);
        int r = 0;
        int x = k;
        for (int i = 0; i < 9; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Natural bin k = 16m + l is held at frame position bitrev9(k).
    function automatic logic signed [DATA_W-1:0] exp_re(input int f, input int m, input int l);
        return stim_re[f][bitrev9(16 * m + l)];
    endfunction

    function automatic logic signed [DATA_W-1:0] exp_im(input int f, input int m, input int l);
        return stim_im[f][bitrev9(16 * m + l)];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_frames(input int nfr, input bit gap);
        for (int f = 0; f < nfr; f++) begin
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                valid_in = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    din_re[l] = stim_re[f][16 * c + l];
                    din_im[l] = stim_im[f][16 * c + l];
                end
                if (f == 0 && c == 31) t31 = cyc;
                if (gap) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                    for (int l = 0; l < LANES; l++) begin
                        din_re[l] = DATA_W'($urandom);
                        din_im[l] = DATA_W'($urandom);
                    end
                end
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic capture(input int n);
        first_cyc = -1;
        timeout   = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                first_cyc = cyc;
                break;
            end
        end
        if (first_cyc < 0) begin
            timeout = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_valid[i] = valid_out;
            cap_idx[i]   = out_idx;
            cap_done[i]  = frame_done;
            for (int l = 0; l < LANES; l++) begin
                cap_re[i][l] = dout_re[l];
                cap_im[i][l] = dout_im[l];
            end
        end
        @(negedge clk);
        cap_after = valid_out;
    endtask

    task automatic fill_random(input int f, input bit extremes);
        for (int n = 0; n < 512; n++) begin
            if (extremes && $urandom_range(0, 1) == 1) begin
                stim_re[f][n] = -13'sd4096;
                stim_im[f][n] = 13'sd4095;
            end else begin
                stim_re[f][n] = DATA_W'($urandom);
                stim_im[f][n] = DATA_W'($urandom);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                din_re[l] = DATA_W'($urandom);
                din_im[l] = DATA_W'($urandom);
            end
            if (i >= 2) begin
                checks++;
                if ({valid_out, frame_done, out_idx} !== 7'd0) begin
                    errors++;
                    $display("FAIL reset_ctrl cyc=%0d: valid=%b done=%b idx=%0d, required all 0",
                             i, valid_out, frame_done, out_idx);
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (dout_re[l] !== '0 || dout_im[l] !== '0) begin
                errors++;
                $display("FAIL reset_dout lane=%0d: re=%0d im=%0d, required 0", l, dout_re[l], dout_im[l]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_ignore_valid cyc=%0d: valid_out=%b, required 0", i, valid_out);
            end
        end
    endtask

    task automatic test_single_ramp();
        for (int n = 0; n < 512; n++) begin
            stim_re[0][n] = DATA_W'(n);
            stim_im[0][n] = DATA_W'(-n);
        end
        fork
            drive_frames(1, 1'b0);
            capture(32);
        join
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL ramp_timeout: valid_out=0, required 1 within budget");
            return;
        end
        checks++;
        if (first_cyc !== t31 + 1) begin
            errors++;
            $display("FAIL ramp_latency: first valid at %0d, required %0d", first_cyc, t31 + 1);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_valid[i] !== 1'b1 || cap_idx[i] !== 5'(i) || cap_done[i] !== (i == 31)) begin
                errors++;
                $display("FAIL ramp_ctrl m=%0d: valid=%b idx=%0d done=%b, required 1 %0d %0d",
                         i, cap_valid[i], cap_idx[i], cap_done[i], i, (i == 31));
            end
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (cap_re[i][l] !== exp_re(0, i, l) || cap_im[i][l] !== exp_im(0, i, l)) begin
                    errors++;
                    $display("FAIL ramp_data m=%0d lane=%0d: got %0d/%0d, required %0d/%0d",
                             i, l, cap_re[i][l], cap_im[i][l], exp_re(0, i, l), exp_im(0, i, l));
                end
            end
        end
        checks++;
        if (cap_re[0][0] !== 13'sd0 || cap_re[0][1] !== 13'sd256 || cap_re[0][2] !== 13'sd128 ||
            cap_re[0][15] !== 13'sd480 || cap_re[1][0] !== 13'sd16) begin
            errors++;
            $display("FAIL ramp_spot: got %0d %0d %0d %0d %0d, required 0 256 128 480 16",
                     cap_re[0][0], cap_re[0][1], cap_re[0][2], cap_re[0][15], cap_re[1][0]);
        end
        checks++;
        if (cap_re[31][15] !== 13'sd511 || cap_im[31][15] !== -13'sd511) begin
            errors++;
            $display("FAIL ramp_last: got %0d/%0d, required 511/-511", cap_re[31][15], cap_im[31][15]);
        end
        checks++;
        if (cap_after !== 1'b0) begin
            errors++;
            $display("FAIL ramp_tail: valid_out=%b after 32 beats, required 0", cap_after);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 512; n++) begin
                stim_re[f][n] = DATA_W'(1000 * f + n);
                stim_im[f][n] = DATA_W'($urandom);
            end
        end
        fork
            drive_frames(3, 1'b0);
            capture(96);
        join
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL b2b_timeout: valid_out=0, required 1 within budget");
            return;
        end
        for (int i = 0; i < 96; i++) begin
            checks++;
            if (cap_valid[i] !== 1'b1 || cap_idx[i] !== 5'(i % 32) || cap_done[i] !== (i % 32 == 31)) begin
                errors++;
                $display("FAIL b2b_ctrl i=%0d: valid=%b idx=%0d done=%b, required 1 %0d %0d",
                         i, cap_valid[i], cap_idx[i], cap_done[i], i % 32, (i % 32 == 31));
            end
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (cap_re[i][l] !== exp_re(i / 32, i % 32, l) || cap_im[i][l] !== exp_im(i / 32, i % 32, l)) begin
                    errors++;
                    $display("FAIL b2b_data i=%0d lane=%0d: got %0d/%0d, required %0d/%0d", i, l,
                             cap_re[i][l], cap_im[i][l], exp_re(i / 32, i % 32, l), exp_im(i / 32, i % 32, l));
                end
            end
        end
        checks++;
        if (cap_after !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: valid_out=%b after 96 beats, required 0", cap_after);
        end
    endtask

    task automatic test_gapped();
        for (int n = 0; n < 512; n++) begin
            stim_re[0][n] = DATA_W'(n);
            stim_im[0][n] = DATA_W'(-n);
        end
        fork
            drive_frames(1, 1'b1);
            capture(32);
        join
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL gap_timeout: valid_out=0, required 1 within budget");
            return;
        end
        checks++;
        if (first_cyc !== t31 + 1) begin
            errors++;
            $display("FAIL gap_latency: first valid at %0d, required %0d", first_cyc, t31 + 1);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_valid[i] !== 1'b1 || cap_idx[i] !== 5'(i) || cap_done[i] !== (i == 31)) begin
                errors++;
                $display("FAIL gap_ctrl m=%0d: valid=%b idx=%0d done=%b", i, cap_valid[i], cap_idx[i], cap_done[i]);
            end
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (cap_re[i][l] !== exp_re(0, i, l) || cap_im[i][l] !== exp_im(0, i, l)) begin
                    errors++;
                    $display("FAIL gap_data m=%0d lane=%0d: got %0d/%0d, required %0d/%0d",
                             i, l, cap_re[i][l], cap_im[i][l], exp_re(0, i, l), exp_im(0, i, l));
                end
            end
        end
    endtask

    task automatic test_extremes();
        fill_random(0, 1'b1);
        fork
            drive_frames(1, 1'b0);
            capture(32);
        join
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL ext_timeout: valid_out=0, required 1 within budget");
            return;
        end
        for (int i = 0; i < 32; i++) begin
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (cap_re[i][l] !== exp_re(0, i, l) || cap_im[i][l] !== exp_im(0, i, l)) begin
                    errors++;
                    $display("FAIL ext_data m=%0d lane=%0d: got %0d/%0d, required %0d/%0d",
                             i, l, cap_re[i][l], cap_im[i][l], exp_re(0, i, l), exp_im(0, i, l));
                end
            end
        end
    endtask

    task automatic test_reset_mid_input();
        fill_random(1, 1'b0);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            valid_in = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                din_re[l] = stim_re[1][16 * c + l];
                din_im[l] = stim_im[1][16 * c + l];
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b0;
        fill_random(0, 1'b0);
        fork
            drive_frames(1, 1'b0);
            capture(32);
        join
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL rstin_timeout: valid_out=0, required 1 within budget");
            return;
        end
        checks++;
        if (first_cyc !== t31 + 1) begin
            errors++;
            $display("FAIL rstin_latency: first valid at %0d, required %0d", first_cyc, t31 + 1);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_idx[i] !== 5'(i) || cap_done[i] !== (i == 31)) begin
                errors++;
                $display("FAIL rstin_ctrl m=%0d: idx=%0d done=%b", i, cap_idx[i], cap_done[i]);
            end
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (cap_re[i][l] !== exp_re(0, i, l) || cap_im[i][l] !== exp_im(0, i, l)) begin
                    errors++;
                    $display("FAIL rstin_data m=%0d lane=%0d: got %0d/%0d, required %0d/%0d",
                             i, l, cap_re[i][l], cap_im[i][l], exp_re(0, i, l), exp_im(0, i, l));
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit found;
        int stray;
        found = 1'b0;
        fill_random(0, 1'b0);
        fork
            drive_frames(1, 1'b0);
            begin
                for (int w = 0; w < 300; w++) begin
                    @(negedge clk);
                    if (valid_out === 1'b1 && out_idx === 5'd10) begin
                        found = 1'b1;
                        break;
                    end
                end
            end
        join
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstrd_reach: out_idx=10 not seen, required within budget");
            return;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid_out, frame_done, out_idx} !== 7'd0) begin
            errors++;
            $display("FAIL rstrd_ctrl: valid=%b done=%b idx=%0d, required all 0", valid_out, frame_done, out_idx);
        end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (dout_re[l] !== '0 || dout_im[l] !== '0) begin
                errors++;
                $display("FAIL rstrd_dout lane=%0d: re=%0d im=%0d, required 0", l, dout_re[l], dout_im[l]);
            end
        end
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_out !== 1'b0 || frame_done !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rstrd_quiet: %0d active cycles after reset, required 0", stray);
        end
        fill_random(0, 1'b0);
        fork
            drive_frames(1, 1'b0);
            capture(32);
        join
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL rstrd_timeout: valid_out=0, required 1 within budget");
            return;
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_idx[i] !== 5'(i) || cap_done[i] !== (i == 31)) begin
                errors++;
                $display("FAIL rstrd_ctrl2 m=%0d: idx=%0d done=%b", i, cap_idx[i], cap_done[i]);
            end
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (cap_re[i][l] !== exp_re(0, i, l) || cap_im[i][l] !== exp_im(0, i, l)) begin
                    errors++;
                    $display("FAIL rstrd_data m=%0d lane=%0d: got %0d/%0d, required %0d/%0d",
                             i, l, cap_re[i][l], cap_im[i][l], exp_re(0, i, l), exp_im(0, i, l));
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int l = 0; l < LANES; l++) begin
            din_re[l] = '0;
            din_im[l] = '0;
        end
        test_reset();
        test_single_ramp();
        test_back_to_back();
        test_gapped();
        test_extremes();
        test_reset_mid_input();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output end of the 512-point FFT pipeline; sits after the final stage-1 CBFP.
- Accepts the FFT result as 16 complex samples per beat, 32 beats per frame, in bit-reversed bin order.
- Emits the same frame in natural bin order, 16 bins per beat, from a ping-pong buffer.
- Is the downstream counterpart of the bench/source that streams 16-lane frames into step0_0.

Parameters:
- DATA_W, 13: signed width of each re/im sample, in and out.
- LANES, 16: samples per beat; fixed at 16.
- N, 512: points per frame; fixed, so beats per frame = N/LANES = 32.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  din_re/din_im carry one valid beat this cycle.
- din_re  in  [0:15] x DATA_W signed  real part of input lanes, bit-reversed order.
- din_im  in  [0:15] x DATA_W signed  imaginary part of input lanes.
- dout_re  out  [0:15] x DATA_W signed  real part of output lanes, natural order.
- dout_im  out  [0:15] x DATA_W signed  imaginary part of output lanes.
- valid_out  out  1  dout_* valid this cycle.
- out_idx  out  5  output beat index m (0..31) within the frame.
- frame_done  out  1  one-cycle pulse coincident with the last output beat (m=31).

Behaviour:
- Indexing: input beat c (0..31), lane l gives frame position n = 16c + l. Position n holds bin bitrev9(n).
- Output mapping: output beat m, lane l emits bin k = 16m + l, taken from stored position bitrev9(k).
- Storage: two banks (A, B), each holding 512 complex entries.
- Write side:
  - wr_cnt (5 b) advances only on valid_in; gaps in valid_in are allowed.
  - Each accepted beat is written to the current write bank at beat wr_cnt.
  - When the beat with wr_cnt=31 is accepted, the write bank toggles, wr_cnt wraps to 0, and that bank is marked full.
- Read side, states IDLE and READ:
  - IDLE -> READ on the edge that accepts write beat 31. rd_bank is set to the just-filled bank and rd_cnt to 0.
  - In READ, outputs are registered. valid_out is high and out_idx = rd_cnt. rd_cnt increments every cycle with no stall.
  - At rd_cnt=31, frame_done=1. Next state is READ (rd_bank toggled) if the other bank completed during this cycle or is already full; otherwise IDLE.
- Latency: valid_out rises the cycle after the clock edge that accepted input beat 31. It stays high for exactly 32 consecutive cycles per frame.
- Back-to-back frames: continuous valid_in produces continuous valid_out with no gap. A bank cannot be rewritten before its read completes, because read and write both take 32 beats.
- Simultaneous write completion and read end: the new frame is read starting the following cycle, with no bubble.
- Samples pass through unmodified: no scaling, no saturation, full signed range preserved.
- Reset (any time, including mid-frame or mid-read):
  - wr_cnt, rd_cnt, bank pointers and full flags clear to 0; state goes to IDLE.
  - valid_out=0, frame_done=0, out_idx=0, all dout_*=0 on the next edge.
  - Any partial input frame and any unread frame are discarded.
- valid_in asserted during reset is ignored.
- dout_* hold 0 whenever valid_out=0.

Test Plan:
- Single frame ramp: re = n, im = -n over 32 contiguous beats. -> valid_out rises 1 cycle after beat 31. At m=0: lane0 re=0, lane1 re=256, lane2 re=128, lane15 re=480. At m=1, lane0 re=16. At m=31, lane15 re=511, im=-511, with frame_done=1.
- Three back-to-back frames, where frame f has re = 1000*f + n. -> 96 consecutive valid_out cycles, out_idx sequence 0..31 three times, three frame_done pulses, per-frame data matches the ramp mapping.
- Gapped input: valid_in toggling 1,0,1,0 (64 cycles for one frame). -> output is identical to the single-frame ramp. valid_out starts only after the 32nd accepted beat.
- Extreme values: all lanes re = -4096, im = +4095 in the same frame as ramp lanes. -> extremes reappear unchanged at their bit-reversed positions; no sign or width corruption.
- Reset at input beat 17, then a fresh full frame. -> no valid_out from the aborted frame. The fresh frame is output correctly starting at out_idx=0.
- Reset during READ at m=10. -> valid_out=0 and dout=0 on the next edge; no frame_done pulse; the next frame is unaffected.
